// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - HD44780 pin bundle driven by lcd_ctrl
interface lcd_ctrl_if;
  logic       o_lcd_on;
  logic       o_lcd_en;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_data;

  modport master (
    output o_lcd_on,
    output o_lcd_en,
    output o_lcd_rs,
    output o_lcd_rw,
    output o_lcd_data
  );

  modport slave (
    input o_lcd_on,
    input o_lcd_en,
    input o_lcd_rs,
    input o_lcd_rw,
    input o_lcd_data
  );
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - LSU LCD register to timed HD44780 write cycles, one-deep pending slot
module lcd_ctrl #(
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  lcd_ctrl_if.master  lcd,
  output logic        o_busy,
  output logic        o_drop
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_t;

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(T_EXEC_LONG - 1);

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_timer, w_next_timer;
  logic             r_tog;
  logic             r_on;
  logic             r_en, w_next_en;
  logic [8:0]       r_act, w_next_act;
  logic             r_pend_valid, w_next_pend_valid;
  logic [8:0]       r_pend_cmd, w_next_pend_cmd;
  logic             r_busy;
  logic             r_drop, w_drop;
  logic             w_send;
  logic [8:0]       w_cmd;
  logic             w_long;
  logic             w_tdone;

  assign w_send  = i_io_lcd[10] ^ r_tog;
  assign w_cmd   = {i_io_lcd[9], i_io_lcd[7:0]};
  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
  assign w_long  = ~r_act[8] & (r_act[7:2] == 6'd0) & (r_act[1:0] != 2'd0);
  assign w_tdone = (r_timer == '0);

  always_comb begin
    w_next_state      = r_state;
    w_next_timer      = r_timer;
    w_next_en         = r_en;
    w_next_act        = r_act;
    w_next_pend_valid = r_pend_valid;
    w_next_pend_cmd   = r_pend_cmd;
    w_drop            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_valid) begin
          w_next_state      = S_SETUP;
          w_next_timer      = L_SETUP;
          w_next_act        = r_pend_cmd;
          w_next_pend_valid = w_send;
          if (w_send) w_next_pend_cmd = w_cmd;
        end else if (w_send) begin
          w_next_state = S_SETUP;
          w_next_timer = L_SETUP;
          w_next_act   = w_cmd;
        end
      end
      default: begin
        if (w_send) begin
          w_drop            = r_pend_valid;
          w_next_pend_valid = 1'b1;
          w_next_pend_cmd   = w_cmd;
        end
        if (!w_tdone) begin
          w_next_timer = r_timer - 1'b1;
        end else begin
          case (r_state)
            S_SETUP: begin
              w_next_state = S_PULSE;
              w_next_timer = L_PULSE;
              w_next_en    = 1'b1;
            end
            S_PULSE: begin
              w_next_state = S_HOLD;
              w_next_timer = L_HOLD;
              w_next_en    = 1'b0;
            end
            S_HOLD: begin
              w_next_state = S_EXEC;
              w_next_timer = w_long ? L_LONG : L_EXEC;
            end
            default: begin
              w_next_state = S_IDLE;
              w_next_timer = '0;
              w_next_en    = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_tog        <= 1'b0;
      r_on         <= 1'b0;
      r_en         <= 1'b0;
      r_act        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_cmd   <= '0;
      r_busy       <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_timer      <= w_next_timer;
      r_tog        <= i_io_lcd[10];
      r_on         <= i_io_lcd[31];
      r_en         <= w_next_en;
      r_act        <= w_next_act;
      r_pend_valid <= w_next_pend_valid;
      r_pend_cmd   <= w_next_pend_cmd;
      r_busy       <= (w_next_state != S_IDLE) | w_next_pend_valid;
      r_drop       <= w_drop;
    end
  end

  assign lcd.o_lcd_on   = r_on;
  assign lcd.o_lcd_en   = r_en;
  assign lcd.o_lcd_rs   = r_act[8];
  assign lcd.o_lcd_rw   = 1'b0;
  assign lcd.o_lcd_data = r_act[7:0];
  assign o_busy         = r_busy;
  assign o_drop         = r_drop;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - scoreboard bench for lcd_ctrl with short timing parameters
module tb_lcd_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io;
  logic        busy, drop;

  always #5 clk = ~clk;

  lcd_ctrl_if lcd();

  lcd_ctrl #(
    .T_SETUP(1), .T_PULSE(3), .T_HOLD(1), .T_EXEC(5), .T_EXEC_LONG(20), .CNT_W(17)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_io_lcd(io),
    .lcd(lcd),
    .o_busy(busy),
    .o_drop(drop)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic tog = 1'b0;
  logic on_r = 1'b0;
  int send_cyc;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int rise_q[$];
  int en_len_q[$];
  int busy_len_q[$];
  int drop_cnt = 0;
  int busy_hi = 0;
  int en_run = 0;
  int busy_run = 0;
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;
  int drop_base, busy_base;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every EN pulse (payload at rise, length at fall) and busy intervals
  always @(negedge clk) begin
    if (lcd.o_lcd_en && !prev_en) begin
      obs_q.push_back({lcd.o_lcd_rs, lcd.o_lcd_data});
      rise_q.push_back(cyc);
      en_run <= 1;
    end else if (lcd.o_lcd_en) begin
      en_run <= en_run + 1;
    end else if (prev_en) begin
      en_len_q.push_back(en_run);
    end
    if (busy && !prev_busy) busy_run <= 1;
    else if (busy) busy_run <= busy_run + 1;
    else if (prev_busy) busy_len_q.push_back(busy_run);
    if (busy) busy_hi <= busy_hi + 1;
    if (drop) drop_cnt <= drop_cnt + 1;
    prev_en <= lcd.o_lcd_en;
    prev_busy <= busy;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    exp_q.delete(); obs_q.delete(); rise_q.delete();
    en_len_q.delete(); busy_len_q.delete();
    drop_base = drop_cnt; busy_base = busy_hi;
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input bit expect_out);
    tick();
    tog = ~tog;
    io = {on_r, 20'b0, tog, rs, 1'b0, d};
    send_cyc = cyc;
    if (expect_out) exp_q.push_back({rs, d});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_total++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; io = '0; tog = 1'b0; on_r = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({lcd.o_lcd_on, lcd.o_lcd_en, lcd.o_lcd_rs, lcd.o_lcd_rw, lcd.o_lcd_data, busy, drop} !== 14'd0)
      $display("FAIL reset_outputs: got %0h required 0",
               {lcd.o_lcd_on, lcd.o_lcd_en, lcd.o_lcd_rs, lcd.o_lcd_rw, lcd.o_lcd_data, busy, drop});
    else n_pass++;
    tick(); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if ({lcd.o_lcd_en, busy} !== 2'b00)
      $display("FAIL reset_idle: en/busy=%0b required 00", {lcd.o_lcd_en, busy});
    else n_pass++;
  endtask

  task automatic test_single();
    int s;
    clear_mon();
    send(1'b0, 8'h41, 1'b1);
    s = send_cyc;
    wait_idle("single");
    n_total++;
    if (obs_q.size() !== 1) $display("FAIL single_count: got %0d pulses required 1", obs_q.size());
    else n_pass++;
    if (obs_q.size() >= 1) begin
      n_total++;
      if (obs_q[0] !== exp_q[0]) $display("FAIL single_data: got %0h required %0h", obs_q[0], exp_q[0]);
      else n_pass++;
      n_total++;
      if (rise_q[0] - s !== 2) $display("FAIL single_en_delay: got %0d required 2", rise_q[0] - s);
      else n_pass++;
    end
    n_total++;
    if (en_len_q.size() < 1 || en_len_q[0] !== 3)
      $display("FAIL single_en_len: got %0d required 3", en_len_q.size() ? en_len_q[0] : -1);
    else n_pass++;
    n_total++;
    if (busy_len_q.size() < 1 || busy_len_q[0] !== 10)
      $display("FAIL single_busy_len: got %0d required 10", busy_len_q.size() ? busy_len_q[0] : -1);
    else n_pass++;
    n_total++;
    if (lcd.o_lcd_rw !== 1'b0) $display("FAIL rw_tied: got %0b required 0", lcd.o_lcd_rw);
    else n_pass++;
  endtask

  task automatic test_long_exec();
    logic [7:0] cmds [2] = '{8'h01, 8'h04};
    int exp_busy [2] = '{25, 10};
    for (int i = 0; i < 2; i++) begin
      clear_mon();
      send(1'b0, cmds[i], 1'b1);
      wait_idle("exec");
      n_total++;
      if (obs_q.size() < 1 || obs_q[0] !== exp_q[0])
        $display("FAIL exec_data_%0h: got %0h required %0h", cmds[i], obs_q.size() ? obs_q[0] : 9'h1ff, exp_q[0]);
      else n_pass++;
      n_total++;
      if (busy_len_q.size() < 1 || busy_len_q[0] !== exp_busy[i])
        $display("FAIL exec_busy_%0h: got %0d required %0d", cmds[i],
                 busy_len_q.size() ? busy_len_q[0] : -1, exp_busy[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send(1'b0, 8'h41, 1'b1);
    tick();
    send(1'b0, 8'h42, 1'b1);
    wait_idle("b2b");
    n_total++;
    if (obs_q.size() !== 2) $display("FAIL b2b_count: got %0d required 2", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_data%0d: got %0h required %0h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    if (rise_q.size() >= 2) begin
      n_total++;
      if (rise_q[1] - rise_q[0] !== 11) $display("FAIL b2b_spacing: got %0d required 11", rise_q[1] - rise_q[0]);
      else n_pass++;
    end
    n_total++;
    if (drop_cnt - drop_base !== 0) $display("FAIL b2b_drop: got %0d required 0", drop_cnt - drop_base);
    else n_pass++;
    n_total++;
    if (busy_len_q.size() !== 1 || busy_len_q[0] !== 21)
      $display("FAIL b2b_busy: got %0d intervals first %0d required 1 of 21",
               busy_len_q.size(), busy_len_q.size() ? busy_len_q[0] : -1);
    else n_pass++;
  endtask

  task automatic test_overwrite();
    clear_mon();
    send(1'b0, 8'h41, 1'b1);
    tick();
    send(1'b0, 8'h42, 1'b0);
    tick();
    send(1'b0, 8'h43, 1'b1);
    wait_idle("ovw");
    n_total++;
    if (obs_q.size() !== 2) $display("FAIL ovw_count: got %0d required 2", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL ovw_data%0d: got %0h required %0h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (drop_cnt - drop_base !== 1) $display("FAIL ovw_drop: got %0d required 1", drop_cnt - drop_base);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_mon();
    send(1'b1, 8'h5a, 1'b0);
    while (lcd.o_lcd_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n >= 50) $display("FAIL mid_en_timeout: en=%0b required 1", lcd.o_lcd_en);
    else n_pass++;
    #2;
    rst_n = 1'b0; io = '0; tog = 1'b0;
    #1;
    n_total++;
    if ({lcd.o_lcd_en, busy, lcd.o_lcd_data} !== 10'd0)
      $display("FAIL mid_async: en/busy/data=%0h required 0", {lcd.o_lcd_en, busy, lcd.o_lcd_data});
    else n_pass++;
    repeat (3) tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (20) tick();
    n_total++;
    if (obs_q.size() !== 0 || busy_hi - busy_base !== 0)
      $display("FAIL mid_no_cmd: pulses=%0d busy_cycles=%0d required 0/0", obs_q.size(), busy_hi - busy_base);
    else n_pass++;
    send(1'b1, 8'h42, 1'b1);
    wait_idle("mid");
    n_total++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL mid_resume: got %0d pulses first %0h required 1 of %0h",
               obs_q.size(), obs_q.size() ? obs_q[0] : 9'h1ff, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_on_bit();
    logic [1:0] lvl = 2'b01;
    clear_mon();
    for (int i = 0; i < 2; i++) begin
      tick();
      on_r = lvl[i];
      io[31] = on_r;
      @(negedge clk);
      n_total++;
      if (lcd.o_lcd_on !== ~on_r) $display("FAIL on_latency%0d: got %0b required %0b", i, lcd.o_lcd_on, ~on_r);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (lcd.o_lcd_on !== on_r) $display("FAIL on_follow%0d: got %0b required %0b", i, lcd.o_lcd_on, on_r);
      else n_pass++;
    end
    repeat (3) tick();
    n_total++;
    if (obs_q.size() !== 0 || busy_hi - busy_base !== 0)
      $display("FAIL on_no_cmd: pulses=%0d busy_cycles=%0d required 0/0", obs_q.size(), busy_hi - busy_base);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_long_exec();
    test_back_to_back();
    test_overwrite();
    test_reset_mid();
    test_on_bit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
